i2s_wavetable_voice: RTL and testbench

Single wavetable voice with a parametrised I2S stereo serialiser. It is the next generation of the synth sound module.
- Steps a phase index through an external wavetable ROM at a note-dependent rate.
- Reads the ROM through a fixed-latency request interface.
- Applies independent left/right gain.
- Shifts the result out as I2S; word width, table depth and divider are all parameters.
- Sits between the MIDI note decoder (note/tick inputs) and the board audio codec pins.

---
 rtl/i2s_wavetable_voice_if.sv | 16 +
 rtl/i2s_wavetable_voice.sv | 148 ++++++++++++++
 tb/tb_i2s_wavetable_voice.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_wavetable_voice_if.sv
// rtl/i2s_wavetable_voice_if.sv - wavetable ROM read bus between the voice and its table memory
//
// tableAddr    : ROM address, driven by the voice
// tableReadEn  : one-cycle read strobe, driven by the voice
// tableData    : signed sample, driven by the ROM a fixed number of cycles after the strobe
interface i2s_wavetable_voice_if #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int TABLE_ADDR_WIDTH = 8
) ();
  logic [TABLE_ADDR_WIDTH-1:0] tableAddr;
  logic                        tableReadEn;
  logic [SAMPLE_WIDTH-1:0]     tableData;

  modport master (output tableAddr, output tableReadEn, input tableData);
  modport slave  (input tableAddr, input tableReadEn, output tableData);
endinterface

// File: rtl/i2s_wavetable_voice.sv
// rtl/i2s_wavetable_voice.sv - single wavetable voice with left/right gain and an I2S serialiser
//
// CLOCK_50           : system clock, rising edge
// RESET_N            : asynchronous active-low reset
// isNoteOn           : note gate, 1 = held
// noteSampleTicks    : clock cycles per table step, minus 1
// leftGain/rightGain : unsigned channel gains, 256 = unity scale
// rom                : wavetable ROM read bus (master side)
// i2sBitClock        : I2S BCLK
// i2sSoundData       : I2S SDATA, MSB first
// i2sLeftRightSelect : I2S LRCK, 0 = left word
// isVoiceActive      : voice audible in the current frame
// frameStrobe        : one-cycle pulse at each frame boundary
module i2s_wavetable_voice #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int TABLE_ADDR_WIDTH = 8,
  parameter int TICK_WIDTH       = 24,
  parameter int I2S_DIV          = 18,
  parameter int ROM_LATENCY      = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  isNoteOn,
  input  logic [TICK_WIDTH-1:0] noteSampleTicks,
  input  logic [7:0]            leftGain,
  input  logic [7:0]            rightGain,
  i2s_wavetable_voice_if.master rom,
  output logic                  i2sBitClock,
  output logic                  i2sSoundData,
  output logic                  i2sLeftRightSelect,
  output logic                  isVoiceActive,
  output logic                  frameStrobe
);
  localparam int DIV_W = $clog2(I2S_DIV + 2);
  localparam int BIT_W = $clog2(SAMPLE_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(I2S_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_WIDTH - 1);

  logic [DIV_W-1:0]            div_cnt;
  logic [BIT_W-1:0]            bit_cnt;
  logic [SAMPLE_WIDTH-1:0]     shadow_left, shadow_right;
  logic [SAMPLE_WIDTH-1:0]     pending_left, pending_right;
  logic                        pending_active;
  logic [TICK_WIDTH-1:0]       tick_cnt;
  logic [TABLE_ADDR_WIDTH-1:0] phase_idx, table_addr;
  logic                        playing, table_rd;
  logic [ROM_LATENCY-1:0]      rd_pipe;

  logic                        bclk_toggle, bclk_fall, word_done, frame_evt, step_evt, capture;
  logic [SAMPLE_WIDTH-1:0]     cur_word;
  logic signed [SAMPLE_WIDTH+8:0] prod_left, prod_right;

  always_comb begin
    bclk_toggle = (div_cnt == DIV_LAST);
    bclk_fall   = bclk_toggle & i2sBitClock;
    word_done   = bclk_fall & (bit_cnt == '0);
    // The LRCK 1->0 toggle (end of the right word) is the frame boundary.
    frame_evt   = word_done & i2sLeftRightSelect;
    step_evt    = (tick_cnt >= noteSampleTicks);
    capture     = rd_pipe[ROM_LATENCY-1];
    cur_word    = i2sLeftRightSelect ? shadow_right : shadow_left;
    // Zero-extended gain keeps the multiply signed without flipping large gains negative.
    prod_left   = $signed(rom.tableData) * $signed({1'b0, leftGain});
    prod_right  = $signed(rom.tableData) * $signed({1'b0, rightGain});
  end

  assign rom.tableAddr   = table_addr;
  assign rom.tableReadEn = table_rd;

  // Bit clock divider, serialiser and frame boundary handling.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt            <= '0;
      i2sBitClock        <= 1'b0;
      i2sSoundData       <= 1'b0;
      i2sLeftRightSelect <= 1'b0;
      bit_cnt            <= BIT_LAST;
      shadow_left        <= '0;
      shadow_right       <= '0;
      isVoiceActive      <= 1'b0;
      frameStrobe        <= 1'b0;
      table_rd           <= 1'b0;
      table_addr         <= '0;
    end else begin
      frameStrobe <= frame_evt;
      table_rd    <= frame_evt;
      if (bclk_toggle) begin
        div_cnt     <= '0;
        i2sBitClock <= ~i2sBitClock;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (bclk_fall) begin
        i2sSoundData <= isVoiceActive & cur_word[bit_cnt];
        if (bit_cnt == '0) begin
          // LRCK changes together with the last bit of the word (one bit early).
          i2sLeftRightSelect <= ~i2sLeftRightSelect;
          bit_cnt            <= BIT_LAST;
        end else begin
          bit_cnt <= bit_cnt - BIT_W'(1);
        end
      end
      if (frame_evt) begin
        shadow_left   <= pending_left;
        shadow_right  <= pending_right;
        isVoiceActive <= pending_active;
        table_addr    <= phase_idx;
      end
    end
  end

  // ROM return path: fixed-latency capture and gain scaling.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pipe        <= '0;
      pending_left   <= '0;
      pending_right  <= '0;
      pending_active <= 1'b0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | ROM_LATENCY'(table_rd);
      if (capture) begin
        pending_left   <= SAMPLE_WIDTH'(prod_left >>> 8);
        pending_right  <= SAMPLE_WIDTH'(prod_right >>> 8);
        pending_active <= playing;
      end
    end
  end

  // Phase stepping. Releasing the gate keeps the voice running until the
  // index wraps to 0 so the note ends on a table boundary without a click.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt  <= '0;
      phase_idx <= '0;
      playing   <= 1'b0;
    end else if (step_evt) begin
      tick_cnt  <= '0;
      phase_idx <= playing ? phase_idx + TABLE_ADDR_WIDTH'(1) : '0;
      if (isNoteOn) begin
        playing <= 1'b1;
      end else if (phase_idx == '0) begin
        playing <= 1'b0;
      end
    end else begin
      tick_cnt <= tick_cnt + TICK_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_i2s_wavetable_voice.sv
// tb/tb_i2s_wavetable_voice.sv - scoreboard bench for i2s_wavetable_voice
module tb_i2s_wavetable_voice;
  localparam int SW          = 16;
  localparam int AW          = 8;
  localparam int TW          = 24;
  localparam int DIV         = 18;
  localparam int LAT         = 1;
  localparam int BCLK_PERIOD = 2 * (DIV + 1);
  localparam int FRAME       = 2 * SW * BCLK_PERIOD;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N = 1'b0;
  logic          isNoteOn = 1'b0;
  logic [TW-1:0] noteSampleTicks = '0;
  logic [7:0]    leftGain = '0;
  logic [7:0]    rightGain = '0;
  logic          i2sBitClock, i2sSoundData, i2sLeftRightSelect, isVoiceActive, frameStrobe;

  i2s_wavetable_voice_if #(.SAMPLE_WIDTH(SW), .TABLE_ADDR_WIDTH(AW)) rom_bus ();

  i2s_wavetable_voice #(
    .SAMPLE_WIDTH(SW), .TABLE_ADDR_WIDTH(AW), .TICK_WIDTH(TW), .I2S_DIV(DIV), .ROM_LATENCY(LAT)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .isNoteOn(isNoteOn),
    .noteSampleTicks(noteSampleTicks),
    .leftGain(leftGain),
    .rightGain(rightGain),
    .rom(rom_bus),
    .i2sBitClock(i2sBitClock),
    .i2sSoundData(i2sSoundData),
    .i2sLeftRightSelect(i2sLeftRightSelect),
    .isVoiceActive(isVoiceActive),
    .frameStrobe(frameStrobe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ROM: constant word or address-dependent pattern, LAT=1 registered read.
  logic          rom_pattern = 1'b0;
  logic [SW-1:0] rom_const = '0;
  always @(posedge CLOCK_50) begin
    if (!RESET_N)
      rom_bus.tableData <= '0;
    else if (rom_bus.tableReadEn)
      rom_bus.tableData <= rom_pattern ? {rom_bus.tableAddr, ~rom_bus.tableAddr} : rom_const;
  end

  // Reference phase stepper.
  logic [TW-1:0] m_tick;
  logic [AW-1:0] m_idx;
  logic          m_play;
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_tick <= '0;
      m_idx  <= '0;
      m_play <= 1'b0;
    end else if (m_tick >= noteSampleTicks) begin
      m_tick <= '0;
      m_idx  <= m_play ? m_idx + 8'd1 : 8'd0;
      if (isNoteOn) m_play <= 1'b1;
      else if (m_idx == 0) m_play <= 1'b0;
    end else begin
      m_tick <= m_tick + 1;
    end
  end

  // floor(d * g / 256) with d signed and g unsigned
  function automatic logic [SW-1:0] scale(input logic [SW-1:0] d, input logic [7:0] g);
    int p, q;
    p = int'($signed(d)) * int'(g);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q[SW-1:0];
  endfunction

  // Scoreboard and I2S receiver.
  logic [SW-1:0] exp_words[$];
  logic          exp_act[$];
  logic          bclk_q, lrck_q, lrck_ch;
  logic [SW-1:0] rx_sr;
  logic [AW-1:0] last_idx;
  int            cyc, cap_cnt, rd_count, last_bclk_rise, last_lrck_rise;

  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      exp_words.delete();
      exp_act.delete();
      // Frame 0 and the first frame after release are both silent.
      for (int i = 0; i < 4; i++) exp_words.push_back('0);
      exp_act.push_back(1'b0);
      bclk_q = 1'b0; lrck_q = 1'b0; lrck_ch = 1'b0; rx_sr = '0; last_idx = '0;
      cyc = 0; cap_cnt = 0; rd_count = 0; last_bclk_rise = -1; last_lrck_rise = -1;
    end else begin
      cyc++;
      if (cap_cnt != 0) begin
        cap_cnt--;
        if (cap_cnt == 0) begin
          exp_words.push_back(m_play ? scale(rom_bus.tableData, leftGain) : '0);
          exp_words.push_back(m_play ? scale(rom_bus.tableData, rightGain) : '0);
          exp_act.push_back(m_play);
        end
      end
      if (rom_bus.tableReadEn) begin
        check_eq("read_addr", 32'(rom_bus.tableAddr), 32'(last_idx));
        cap_cnt = LAT;
        rd_count++;
      end
      if (frameStrobe) begin
        check_eq("reads_per_frame", rd_count, 1);
        rd_count = 0;
        check_eq("sb_active_avail", 32'(exp_act.size() != 0), 1);
        if (exp_act.size() != 0) check_eq("voice_active", 32'(isVoiceActive), 32'(exp_act.pop_front()));
      end
      if (i2sBitClock && !bclk_q) begin
        if (last_bclk_rise >= 0) check_eq("bclk_period", cyc - last_bclk_rise, BCLK_PERIOD);
        last_bclk_rise = cyc;
        rx_sr = {rx_sr[SW-2:0], i2sSoundData};
        if (i2sLeftRightSelect != lrck_ch) begin
          check_eq("sb_word_avail", 32'(exp_words.size() != 0), 1);
          if (exp_words.size() != 0) begin
            if (lrck_ch) check_eq("right_word", 32'(rx_sr), 32'(exp_words.pop_front()));
            else         check_eq("left_word", 32'(rx_sr), 32'(exp_words.pop_front()));
          end
        end
        lrck_ch = i2sLeftRightSelect;
      end
      if (i2sLeftRightSelect != lrck_q) begin
        check_eq("lrck_on_bclk_fall", {30'd0, bclk_q, i2sBitClock}, 2);
        if (i2sLeftRightSelect) begin
          if (last_lrck_rise >= 0) check_eq("lrck_period", cyc - last_lrck_rise, FRAME);
          last_lrck_rise = cyc;
        end
      end
      bclk_q   = i2sBitClock;
      lrck_q   = i2sLeftRightSelect;
      last_idx = m_idx;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < (n + 4) * FRAME && seen < n; i++) begin
      tick(1);
      if (frameStrobe) seen++;
    end
    check_eq("frame_count", seen, n);
  endtask

  // Reset with random inputs, check quiet outputs, release and time the first BCLK toggle.
  task automatic reset_and_release(input int hold);
    int first;
    RESET_N = 1'b0;
    isNoteOn = 1'($urandom);
    noteSampleTicks = TW'($urandom);
    {leftGain, rightGain} = 16'($urandom);
    rom_const = SW'($urandom);
    tick(hold);
    check_eq("reset_outputs", {18'd0, i2sBitClock, i2sSoundData, i2sLeftRightSelect, isVoiceActive,
             frameStrobe, rom_bus.tableReadEn, rom_bus.tableAddr}, 0);
    RESET_N = 1'b1;
    first = 0;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      if (i2sBitClock) begin
        first = k;
        break;
      end
    end
    check_eq("first_bclk_toggle", first, DIV + 1);
  endtask

  initial begin
    #(80000 * 20);
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] base, want;
    int found;

    reset_and_release(3);

    // Gain 128/64 on 0x4000 -> 0x2000 / 0x1000
    isNoteOn = 1'b1; noteSampleTicks = 3; rom_pattern = 1'b0;
    rom_const = 16'h4000; leftGain = 8'd128; rightGain = 8'd64;
    wait_frames(4);
    check_eq("gain_active", 32'(isVoiceActive), 1);

    // Most negative sample at near-unity gain, then zero gain
    rom_const = 16'h8000; leftGain = 8'd255; rightGain = 8'd255;
    wait_frames(3);
    leftGain = 8'd0; rightGain = 8'd0;
    wait_frames(3);

    // Address-dependent data, stepping every cycle
    rom_pattern = 1'b1; leftGain = 8'd200; rightGain = 8'd33; noteSampleTicks = 0;
    tick(2);
    base = m_idx;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      want = base + AW'(k);
      check_eq("fast_step_idx", 32'(dut.phase_idx), 32'(want));
    end
    wait_frames(3);

    // Lowering the tick count mid-count steps on the very next cycle
    noteSampleTicks = 1000;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (m_tick == 500) begin
        found = 1;
        break;
      end
    end
    check_eq("rate_wait", found, 1);
    base = m_idx;
    check_eq("rate_pre_idx", 32'(dut.phase_idx), 32'(base));
    noteSampleTicks = 5;
    tick(1);
    want = base + 8'd1;
    check_eq("rate_edge_step", 32'(dut.phase_idx), 32'(want));

    // Release at index 100: run to the wrap, then go silent
    noteSampleTicks = 3; isNoteOn = 1'b1;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (m_idx == 100) begin
        found = 1;
        break;
      end
    end
    check_eq("release_wait_idx", found, 1);
    isNoteOn = 1'b0;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (!m_play) begin
        found = 1;
        break;
      end
    end
    check_eq("release_wait_clear", found, 1);
    check_eq("release_playing", 32'(dut.playing), 0);
    // The clearing step still sees playing=1, so the index moves 0 -> 1 once more.
    check_eq("release_idx", 32'(dut.phase_idx), 1);
    tick(8);
    check_eq("release_idx_parked", 32'(dut.phase_idx), 0);
    wait_frames(3);
    check_eq("release_muted", 32'(isVoiceActive), 0);

    // Reset in the middle of a frame, then resume playing
    isNoteOn = 1'b1; leftGain = 8'd90; rightGain = 8'd170;
    tick(500);
    reset_and_release(4);
    isNoteOn = 1'b1; noteSampleTicks = 2; rom_pattern = 1'b1;
    leftGain = 8'd90; rightGain = 8'd170;
    wait_frames(4);
    check_eq("resume_active", 32'(isVoiceActive), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
